ro_slot_scheduler: RTL

Time-slot scheduler for the shared readout bus. Each core's ro_block_2x tristate drives the bus on edges of its gray-count bit.
The block owns the global gray counter on clk_master and decodes, each cycle, the single gray bit that toggled into a one-hot slot grant. This guarantees exactly one core (or none) drives the bus per cycle.
It also adds run/sync control, per-channel masking and sticky slot-miss flags for readout debug.

---
 rtl/ro_pkg.sv | 21 ++
 rtl/ro_gray_ctr.sv | 35 +++
 rtl/ro_slot_scheduler.sv | 90 +++++++++
 3 files changed

// File: rtl/ro_pkg.sv
// Shared constants and helpers for the readout slot scheduler.
package ro_pkg;

    localparam int RO_N_CH  = 19;
    localparam int RO_IDX_W = 5;

    // Index of the lowest set bit among the low n_ch bits of v.
    // An all-zero vector means the counter wrapped, which toggles the gray MSB.
    function automatic logic [RO_IDX_W-1:0] tz_count(input logic [RO_N_CH-1:0] v,
                                                     input int                 n_ch);
        logic [RO_IDX_W-1:0] idx;
        idx = RO_IDX_W'(n_ch - 1);
        for (int i = RO_N_CH - 1; i >= 0; i--) begin
            if ((i < n_ch) && v[i]) begin
                idx = RO_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ro_gray_ctr.sv
// Global binary/gray counter for the readout bus; both views update on the same edge.
module ro_gray_ctr #(
    parameter int N_CH = 19
) (
    input  logic            clk_master,
    input  logic            rstb,
    input  logic            en,
    input  logic            clr,
    output logic [N_CH-1:0] cnt,
    output logic [N_CH-1:0] gray,
    output logic            wrap
);

    logic [N_CH-1:0] cnt_nxt;

    assign cnt_nxt = cnt + 1'b1;

    // Asserted in the cycle whose edge will take the counter from all-ones to zero.
    assign wrap = en & ~clr & (&cnt);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt  <= '0;
            gray <= '0;
        end else if (clr) begin
            cnt  <= '0;
            gray <= '0;
        end else if (en) begin
            cnt  <= cnt_nxt;
            gray <= cnt_nxt ^ (cnt_nxt >> 1);
        end
    end

endmodule

// File: rtl/ro_slot_scheduler.sv
// Readout bus time-slot scheduler: decodes the toggling gray bit into a one-hot grant,
// applies channel masks and keeps sticky per-channel slot-miss flags.
module ro_slot_scheduler
    import ro_pkg::*;
#(
    parameter int N_CH  = RO_N_CH,   // must not exceed RO_N_CH
    parameter int IDX_W = RO_IDX_W
) (
    input  logic             clk_master,
    input  logic             rstb,
    input  logic             run,
    input  logic             sync_clr,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [N_CH-1:0]  ch_rdy,
    input  logic             clr_err,
    output logic [N_CH-1:0]  gray,
    output logic [N_CH-1:0]  slot_en,
    output logic [IDX_W-1:0] slot_idx,
    output logic             slot_valid,
    output logic             frame_start,
    output logic [N_CH-1:0]  miss
);

    logic             advance;
    logic             wrap;
    logic [N_CH-1:0]  cnt;
    logic [N_CH-1:0]  cnt_nxt;
    logic [IDX_W-1:0] k;
    logic [N_CH-1:0]  grant_oh;

    logic [N_CH-1:0]  slot_en_d;
    logic [IDX_W-1:0] slot_idx_d;
    logic             slot_valid_d;
    logic             frame_start_d;
    logic [N_CH-1:0]  miss_d;

    assign advance = run & ~sync_clr;

    ro_gray_ctr #(
        .N_CH (N_CH)
    ) u_ctr (
        .clk_master (clk_master),
        .rstb       (rstb),
        .en         (advance),
        .clr        (sync_clr),
        .cnt        (cnt),
        .gray       (gray),
        .wrap       (wrap)
    );

    // The gray bit that toggles on cnt -> cnt+1 is the trailing-zero count of cnt+1.
    assign cnt_nxt  = cnt + 1'b1;
    assign k        = IDX_W'(tz_count(RO_N_CH'(cnt_nxt), N_CH));
    assign grant_oh = N_CH'(1) << k;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        slot_en_d     = '0;
        slot_idx_d    = slot_idx;
        slot_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        miss_d        = clr_err ? '0 : miss;

        if (advance) begin
            slot_idx_d    = k;
            slot_en_d     = grant_oh & ~ch_mask;
            slot_valid_d  = |(grant_oh & ~ch_mask);
            frame_start_d = wrap;
            // Setting after the clear lets a coincident new miss survive clr_err.
            miss_d        = miss_d | (grant_oh & ~ch_mask & ~ch_rdy);
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            slot_en     <= '0;
            slot_idx    <= '0;
            slot_valid  <= 1'b0;
            frame_start <= 1'b0;
            miss        <= '0;
        end else begin
            slot_en     <= slot_en_d;
            slot_idx    <= slot_idx_d;
            slot_valid  <= slot_valid_d;
            frame_start <= frame_start_d;
            miss        <= miss_d;
        end
    end

endmodule
